tx_symbol_scheduler: RTL and testbench

Transmit-side symbol sequencer placed directly in front of the 8b/10b encoder in the PHY TX path. Every enabled cycle it presents exactly one 8-bit symbol plus K flag to the encoder. Each symbol is one of: a user byte, logical idle (D0.0), or a periodically inserted SKP ordered set (COM followed by SKP symbols) for receiver clock compensation. It owns the encoder's `in_8b`/`K` inputs and is the only block allowed to drive them.

---
 rtl/tx_symbol_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tx_symbol_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_symbol_scheduler.sv
// Symbol sequencer in front of the 8b/10b encoder: user bytes, logical idle and periodic SKP ordered sets.
// Define TX_SKP_EN to build SKP ordered-set insertion; without it the block is a plain 1-cycle data pipe.
module tx_symbol_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       k_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       sym_valid,
    output logic       skp_active
);

    if (SKP_INTERVAL < 2 || SKP_INTERVAL > 4095 || SKP_COUNT < 1 || SKP_COUNT > 7) begin : g_bad_param
        $error("tx_symbol_scheduler: SKP_INTERVAL or SKP_COUNT out of range");
    end

    logic [7:0] enc_data_next;
    logic       enc_k_next;
    logic       sym_valid_next;
    logic       skp_active_next;
    logic       accept;

    assign accept = data_valid && data_ready;

`ifdef TX_SKP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_COM, ST_SKP, ST_DATA} state_t;

    localparam int IW = $clog2(SKP_INTERVAL);
    localparam logic [IW-1:0] INT_LAST = IW'(SKP_INTERVAL - 1);
    localparam logic [2:0]    SKP_LAST = 3'(SKP_COUNT - 1);

    state_t        state_reg, state_next;
    logic [IW-1:0] int_cnt_reg, int_cnt_next;
    logic [2:0]    skp_cnt_reg, skp_cnt_next;

    always_comb begin
        state_next   = state_reg;
        int_cnt_next = int_cnt_reg;
        skp_cnt_next = skp_cnt_reg;
        data_ready   = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_COM;
            ST_COM: begin
                state_next   = ST_SKP;
                int_cnt_next = '0;
                skp_cnt_next = '0;
            end
            ST_SKP: begin
                skp_cnt_next = skp_cnt_reg + 3'd1;
                if (skp_cnt_reg == SKP_LAST) begin
                    state_next = ST_DATA;
                    data_ready = 1'b1;
                end
            end
            ST_DATA: begin
                if (int_cnt_reg == INT_LAST) begin
                    state_next = ST_COM;
                end else begin
                    int_cnt_next = int_cnt_reg + 1'b1;
                    data_ready   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Dropping enable aborts any ordered set in flight and refuses the byte on offer.
        if (!enable || reset) begin
            state_next   = ST_IDLE;
            int_cnt_next = '0;
            skp_cnt_next = '0;
            data_ready   = 1'b0;
        end
    end

    always_comb begin
        enc_data_next   = 8'h00;
        enc_k_next      = 1'b0;
        sym_valid_next  = 1'b0;
        skp_active_next = 1'b0;
        case (state_next)
            ST_COM: begin
                enc_data_next   = 8'hBC;
                enc_k_next      = 1'b1;
                sym_valid_next  = 1'b1;
                skp_active_next = 1'b1;
            end
            ST_SKP: begin
                enc_data_next   = 8'h1C;
                enc_k_next      = 1'b1;
                sym_valid_next  = 1'b1;
                skp_active_next = 1'b1;
            end
            ST_DATA: begin
                enc_data_next  = accept ? data_in : 8'h00;
                enc_k_next     = accept ? k_in : 1'b0;
                sym_valid_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            int_cnt_reg <= '0;
            skp_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            int_cnt_reg <= int_cnt_next;
            skp_cnt_reg <= skp_cnt_next;
        end
    end
`else
    typedef enum logic {ST_IDLE, ST_DATA} state_t;

    state_t state_reg, state_next;

    always_comb begin
        state_next      = (enable && !reset) ? ST_DATA : ST_IDLE;
        data_ready      = enable && !reset;
        enc_data_next   = 8'h00;
        enc_k_next      = 1'b0;
        sym_valid_next  = 1'b0;
        skp_active_next = 1'b0;
        if (state_next == ST_DATA) begin
            enc_data_next  = accept ? data_in : 8'h00;
            enc_k_next     = accept ? k_in : 1'b0;
            sym_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            enc_data   <= 8'h00;
            enc_k      <= 1'b0;
            sym_valid  <= 1'b0;
            skp_active <= 1'b0;
        end else begin
            enc_data   <= enc_data_next;
            enc_k      <= enc_k_next;
            sym_valid  <= sym_valid_next;
            skp_active <= skp_active_next;
        end
    end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Testbench for tx_symbol_scheduler (SKP_INTERVAL=4, SKP_COUNT=3); follows TX_SKP_EN like the design.
// The reference model tracks the symbol index since enable and derives each slot from its position in the insertion period.
module tb_tx_symbol_scheduler;

    localparam int SI = 4;
    localparam int SC = 3;
    localparam int PERIOD = SI + 1 + SC;
    localparam int K_COM = 1, K_SKP = 2, K_DATA = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       k_in = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       sym_valid;
    logic       skp_active;

    tx_symbol_scheduler #(.SKP_INTERVAL(SI), .SKP_COUNT(SC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .k_in(k_in),
        .data_valid(data_valid), .data_ready(data_ready), .enc_data(enc_data),
        .enc_k(enc_k), .sym_valid(sym_valid), .skp_active(skp_active)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: index of the next symbol within the current enabled run.
    int         n = 0;
    logic       obs_ready, exp_ready, last_acc;
    logic [7:0] exp_data;
    logic       exp_k, exp_sym, exp_skp;

    byte sd [13] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h10, 8'h11, 8'h12, 8'h13,
                     8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h14};
    bit  sk [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic int kind(input int idx);
`ifdef TX_SKP_EN
        int p;
        p = idx % PERIOD;
        if (p == 0) return K_COM;
        if (p <= SC) return K_SKP;
        return K_DATA;
`else
        return K_DATA;
`endif
    endfunction

    // Drive one cycle, record the DUT's ready and the model's predictions, sample after the edge.
    task automatic tick(input logic rst, input logic en, input logic vld,
                        input logic [7:0] d, input logic kk);
        @(negedge clk);
        reset = rst; enable = en; data_valid = vld; data_in = d; k_in = kk;
        #1;
        obs_ready = data_ready;
        exp_ready = !rst && en && (kind(n) == K_DATA);
        last_acc  = exp_ready && vld;
        if (rst || !en) begin
            exp_data = 8'h00; exp_k = 1'b0; exp_sym = 1'b0; exp_skp = 1'b0;
            n = 0;
        end else begin
            case (kind(n))
                K_COM:   begin exp_data = 8'hBC; exp_k = 1'b1; exp_skp = 1'b1; end
                K_SKP:   begin exp_data = 8'h1C; exp_k = 1'b1; exp_skp = 1'b1; end
                default: begin
                    exp_data = last_acc ? d : 8'h00;
                    exp_k    = last_acc ? kk : 1'b0;
                    exp_skp  = 1'b0;
                end
            endcase
            exp_sym = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1);
            tests_run++;
            if ({obs_ready, enc_data, enc_k, sym_valid, skp_active} !== 12'h000) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got rdy/data/k/vld/skp=%b/%h/%b/%b/%b required 0/00/0/0/0",
                         i, obs_ready, enc_data, enc_k, sym_valid, skp_active);
            end
        end
    endtask

    task automatic test_startup();
        logic [7:0] b;
        int len;
        b = 8'h10;
`ifdef TX_SKP_EN
        len = 13;
`else
        len = 20;
`endif
        for (int i = 0; i < len; i++) begin
            logic [7:0] rd;
            logic       rk;
            tick(1'b0, 1'b1, 1'b1, b, 1'b0);
            if (last_acc) b++;
`ifdef TX_SKP_EN
            rd = sd[i]; rk = sk[i];
`else
            rd = 8'(8'h10 + i); rk = 1'b0;
`endif
            tests_run++;
            if ({enc_data, enc_k, sym_valid, skp_active, obs_ready} !== {rd, rk, 1'b1, rk, exp_ready}) begin
                tests_failed++;
                $display("FAIL startup[%0d]: got data/k/vld/skp/rdy=%h/%b/%b/%b/%b required %h/%b/1/%b/%b",
                         i, enc_data, enc_k, sym_valid, skp_active, obs_ready, rd, rk, rk, exp_ready);
            end
        end
        tests_run++;
`ifdef TX_SKP_EN
        if (b !== 8'h15) begin
`else
        if (b !== 8'h24) begin
`endif
            tests_failed++;
            $display("FAIL startup_count: next byte %h, bytes consumed wrong", b);
        end
    endtask

    task automatic test_idle_fill();
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h77, 1'b1);
            tests_run++;
            if ({obs_ready, enc_data, enc_k, sym_valid, skp_active} !==
                {exp_ready, exp_data, exp_k, exp_sym, exp_skp}) begin
                tests_failed++;
                $display("FAIL idle_fill[%0d]: got rdy/data/k/vld/skp=%b/%h/%b/%b/%b required %b/%h/%b/%b/%b",
                         i, obs_ready, enc_data, enc_k, sym_valid, skp_active,
                         exp_ready, exp_data, exp_k, exp_sym, exp_skp);
            end
`ifdef TX_SKP_EN
            if (i == 8) begin
                tests_run++;
                if ({enc_data, enc_k} !== {8'hBC, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL idle_fill_com: got %h/%b required BC/1", enc_data, enc_k);
                end
            end
`endif
        end
    endtask

    task automatic test_kpass();
        int guard;
        guard = 0;
        while (kind(n) != K_DATA && guard < 20) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            guard++;
        end
        tick(1'b0, 1'b1, 1'b1, 8'hFB, 1'b1);
        tests_run++;
        if ({obs_ready, enc_data, enc_k, sym_valid, skp_active} !== {1'b1, 8'hFB, 1'b1, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL kpass: got rdy/data/k/vld/skp=%b/%h/%b/%b/%b required 1/fb/1/1/0",
                     obs_ready, enc_data, enc_k, sym_valid, skp_active);
        end
    endtask

    task automatic test_abort();
        logic [8:0] os [4];
        os[0] = {8'hBC, 1'b1}; os[1] = {8'h1C, 1'b1}; os[2] = {8'h1C, 1'b1}; os[3] = {8'h1C, 1'b1};
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef TX_SKP_EN
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        tests_run++;
        if ({obs_ready, enc_data, enc_k, sym_valid, skp_active} !== 12'h000) begin
            tests_failed++;
            $display("FAIL abort_mid: got rdy/data/k/vld/skp=%b/%h/%b/%b/%b required 0/00/0/0/0",
                     obs_ready, enc_data, enc_k, sym_valid, skp_active);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
            tests_run++;
            if ({enc_data, enc_k, skp_active, obs_ready} !== {os[i], 1'b1, 1'b0}) begin
                tests_failed++;
                $display("FAIL abort_restart[%0d]: got data/k/skp/rdy=%h/%b/%b/%b required %h/%b/1/0",
                         i, enc_data, enc_k, skp_active, obs_ready, os[i][8:1], os[i][0]);
            end
        end
`else
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
`endif
        tick(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
        tests_run++;
        if ({obs_ready, enc_data, enc_k, sym_valid, skp_active} !== 12'h000) begin
            tests_failed++;
            $display("FAIL abort_last: got rdy/data/k/vld/skp=%b/%h/%b/%b/%b required 0/00/0/0/0",
                     obs_ready, enc_data, enc_k, sym_valid, skp_active);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       bk;
        b = 8'($urandom); bk = 1'($urandom);
        for (int i = 0; i < 400; i++) begin
            logic r, e, v;
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 29) != 0);
            v = $urandom_range(0, 1) == 1;
            tick(r, e, v, b, bk);
            if (last_acc) begin
                b = 8'($urandom); bk = 1'($urandom);
            end
            tests_run++;
            if ({obs_ready, enc_data, enc_k, sym_valid, skp_active} !==
                {exp_ready, exp_data, exp_k, exp_sym, exp_skp}) begin
                tests_failed++;
                $display("FAIL random[%0d]: got rdy/data/k/vld/skp=%b/%h/%b/%b/%b required %b/%h/%b/%b/%b",
                         i, obs_ready, enc_data, enc_k, sym_valid, skp_active,
                         exp_ready, exp_data, exp_k, exp_sym, exp_skp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_idle_fill();
        test_kpass();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
